// File: rtl/uart_16550_tx_serializer_if.sv
// Tx serializer bus bundle: FIFO head, LCR and baud strobe in; pop, SOUT and status out.
// master = FIFO/register side, slave = serializer.
interface uart_16550_tx_serializer_if;
    logic       Baud_Tick_i;
    logic [6:0] LCR_i;
    logic [7:0] Tx_FIFO_DAT_i;
    logic       Tx_FIFO_Empty_i;
    logic       Tx_FIFO_Pop_o;
    logic       SOUT_o;
    logic       Tx_Busy_o;
    logic       Tx_Shift_Empty_o;
    logic       Frame_Done_o;

    modport master (
        output Baud_Tick_i,
        output LCR_i,
        output Tx_FIFO_DAT_i,
        output Tx_FIFO_Empty_i,
        input  Tx_FIFO_Pop_o,
        input  SOUT_o,
        input  Tx_Busy_o,
        input  Tx_Shift_Empty_o,
        input  Frame_Done_o
    );

    modport slave (
        input  Baud_Tick_i,
        input  LCR_i,
        input  Tx_FIFO_DAT_i,
        input  Tx_FIFO_Empty_i,
        output Tx_FIFO_Pop_o,
        output SOUT_o,
        output Tx_Busy_o,
        output Tx_Shift_Empty_o,
        output Frame_Done_o
    );
endinterface

// File: rtl/uart_16550_tx_serializer.sv
// UART 16550 transmit serializer: pops Tx FIFO bytes and shifts LCR-framed frames on SOUT.
// Optional UART_TX_LOOPBACK_EN adds Loopback_i / Loop_SOUT_o for MCR loopback.
module uart_16550_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                      WBs_CLK_i,
    input  logic                      WBs_RST_i,
`ifdef UART_TX_LOOPBACK_EN
    input  logic                      Loopback_i,
    output logic                      Loop_SOUT_o,
`endif
    uart_16550_tx_serializer_if.slave tx_if
);

    localparam int CW = $clog2(OVERSAMPLE * 2);

    localparam logic [CW-1:0] LP_BIT_LAST    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] LP_STOP15_LAST = CW'((OVERSAMPLE * 3) / 2 - 1);
    localparam logic [CW-1:0] LP_STOP2_LAST  = CW'(OVERSAMPLE * 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [1:0]    r_wls;
    logic          r_stb;
    logic          r_pen;
    logic          r_par_bit;
    logic          r_pop;
    logic          r_pop_d1;
    logic          r_busy;
    logic          r_done;
    logic          r_sout;
`ifdef UART_TX_LOOPBACK_EN
    logic          r_loop_sout;
`endif

    logic [7:0]    w_dat_mask;
    logic          w_par_bit;
    logic [CW-1:0] w_stop_last;
    logic [CW-1:0] w_tick_last;
    logic          w_tick_end;
    logic          w_bit_last;
    logic          w_pop_ok;
    logic          w_stream;
    logic          w_line;

    always_comb begin
        w_dat_mask = tx_if.Tx_FIFO_DAT_i;
        unique case (tx_if.LCR_i[1:0])
            2'b00:   w_dat_mask = {3'b000, tx_if.Tx_FIFO_DAT_i[4:0]};
            2'b01:   w_dat_mask = {2'b00, tx_if.Tx_FIFO_DAT_i[5:0]};
            2'b10:   w_dat_mask = {1'b0, tx_if.Tx_FIFO_DAT_i[6:0]};
            default: w_dat_mask = tx_if.Tx_FIFO_DAT_i;
        endcase
    end

    // EPS/stick are folded into one parity bit at capture time
    assign w_par_bit = tx_if.LCR_i[5] ? ~tx_if.LCR_i[4]
                     : (tx_if.LCR_i[4] ? ^w_dat_mask : ~^w_dat_mask);

    assign w_stop_last = !r_stb ? LP_BIT_LAST
                       : ((r_wls == 2'b00) ? LP_STOP15_LAST : LP_STOP2_LAST);

    assign w_tick_last = (r_state == S_STOP) ? w_stop_last : LP_BIT_LAST;
    assign w_tick_end  = tx_if.Baud_Tick_i && (r_tick_cnt == w_tick_last);
    assign w_bit_last  = (r_bit_cnt == {1'b1, r_wls});
    assign w_pop_ok    = !tx_if.Tx_FIFO_Empty_i && !r_pop && !r_pop_d1;

    always_comb begin
        w_stream = 1'b1;
        unique case (r_state)
            S_START:  w_stream = 1'b0;
            S_DATA:   w_stream = r_shift[0];
            S_PARITY: w_stream = r_par_bit;
            default:  w_stream = 1'b1;
        endcase
    end

    assign w_line = ~tx_if.LCR_i[6] & w_stream;

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_wls      <= '0;
            r_stb      <= 1'b0;
            r_pen      <= 1'b0;
            r_par_bit  <= 1'b0;
            r_pop      <= 1'b0;
            r_pop_d1   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sout     <= 1'b1;
`ifdef UART_TX_LOOPBACK_EN
            r_loop_sout <= 1'b1;
`endif
        end else begin
            r_pop    <= 1'b0;
            r_done   <= 1'b0;
            r_pop_d1 <= r_pop;

`ifdef UART_TX_LOOPBACK_EN
            r_sout      <= Loopback_i ? 1'b1 : w_line;
            r_loop_sout <= Loopback_i ? w_line : 1'b1;
`else
            r_sout <= w_line;
`endif

            if (r_state != S_IDLE && tx_if.Baud_Tick_i) begin
                r_tick_cnt <= w_tick_end ? '0 : r_tick_cnt + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_pop_ok) begin
                        r_pop      <= 1'b1;
                        r_shift    <= w_dat_mask;
                        r_wls      <= tx_if.LCR_i[1:0];
                        r_stb      <= tx_if.LCR_i[2];
                        r_pen      <= tx_if.LCR_i[3];
                        r_par_bit  <= w_par_bit;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (w_bit_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_pen ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick_end) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick_end) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_if.Tx_FIFO_Pop_o    = r_pop;
    assign tx_if.SOUT_o           = r_sout;
    assign tx_if.Tx_Busy_o        = r_busy;
    assign tx_if.Frame_Done_o     = r_done;
    assign tx_if.Tx_Shift_Empty_o = (r_state == S_IDLE) & tx_if.Tx_FIFO_Empty_i;
`ifdef UART_TX_LOOPBACK_EN
    assign Loop_SOUT_o            = r_loop_sout;
`endif

endmodule

// File: tb/tb_uart_16550_tx_serializer.sv
// Directed bench for uart_16550_tx_serializer: FIFO model, frame scoreboard,
// tick-counted bit sampling, reset and break scenarios.
module tb_uart_16550_tx_serializer;

    typedef struct {
        logic [11:0] bits;
        int          nb;
        int          tt;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_16550_tx_serializer_if tx_if();

    uart_16550_tx_serializer #(.OVERSAMPLE(16)) dut (
        .WBs_CLK_i (clk),
        .WBs_RST_i (rst),
        .tx_if     (tx_if)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     tick_div = 1;
    int     tick_cnt = 0;
    int     cyc      = 0;
    int     last_pop = -1;
    int     min_gap  = 1000000;
    int     pop_cnt  = 0;
    int     underflow = 0;
    logic [7:0] fifo_q[$];
    frame_t     sb[$];

    always @(posedge clk) begin
        #1;
        tick_cnt++;
        tx_if.Baud_Tick_i = (tick_div <= 1) || ((tick_cnt % tick_div) == 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (tx_if.Tx_FIFO_Pop_o === 1'b1) begin
            pop_cnt++;
            if (last_pop >= 0 && (cyc - last_pop) < min_gap)
                min_gap = cyc - last_pop;
            last_pop = cyc;
            if (fifo_q.size() == 0) underflow++;
            else void'(fifo_q.pop_front());
        end
        tx_if.Tx_FIFO_Empty_i = (fifo_q.size() == 0);
        tx_if.Tx_FIFO_DAT_i   = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic frame_t mk(input logic [6:0] lcr, input logic [7:0] d);
        frame_t f;
        int     n;
        logic   p;
        n = 5 + int'(lcr[1:0]);
        p = 1'b0;
        f.bits = '0;
        f.nb = 1;
        for (int i = 0; i < n; i++) begin
            f.bits[f.nb] = d[i];
            p = p ^ d[i];
            f.nb++;
        end
        if (lcr[3]) begin
            f.bits[f.nb] = lcr[5] ? ~lcr[4] : (lcr[4] ? p : ~p);
            f.nb++;
        end
        f.bits[f.nb] = 1'b1;
        f.nb++;
        f.tt = 16 * (f.nb - 1) + (!lcr[2] ? 16 : (n == 5 ? 24 : 32));
        return f;
    endfunction

    task automatic queue_frame(input logic [6:0] lcr, input logic [7:0] d);
        tx_if.LCR_i = lcr;
        sb.push_back(mk(lcr, d));
        fifo_q.push_back(d);
    endtask

    task automatic wait_pop(input string tag, output bit got);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (tx_if.Tx_FIFO_Pop_o === 1'b1) got = 1'b1;
        end
        chk({tag, " pop"}, 32'(got), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic exp_empty);
        frame_t f;
        int     ticks;
        bit     tk;
        bit     got;
        bit     done;
        f = sb.pop_front();
        wait_pop(tag, got);
        if (!got) return;
        ticks = 0;
        done  = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            tk = tx_if.Baud_Tick_i;
            @(negedge clk);
            if (tk) begin
                ticks++;
                if (ticks == 8) chk({tag, " busy"}, 32'(tx_if.Tx_Busy_o), 32'd1);
                for (int b = 0; b < f.nb; b++)
                    if (ticks == 16 * b + 8)
                        chk($sformatf("%s b%0d", tag, b),
                            32'(tx_if.SOUT_o), 32'(f.bits[b]));
            end
            if (tx_if.Frame_Done_o === 1'b1) begin
                done = 1'b1;
                chk({tag, " ticks"}, ticks, f.tt);
                chk({tag, " idle"}, 32'(tx_if.SOUT_o), 32'd1);
                chk({tag, " temt"}, 32'(tx_if.Tx_Shift_Empty_o), 32'(exp_empty));
            end
        end
        chk({tag, " done"}, 32'(done), 32'd1);
    endtask

    int k;
    int pc0;
    bit got;
    bit done;

    initial begin
        tx_if.LCR_i = 7'h03;
        tx_if.Baud_Tick_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst sout", 32'(tx_if.SOUT_o), 32'd1);
        chk("rst pop", 32'(tx_if.Tx_FIFO_Pop_o), 32'd0);
        chk("rst busy", 32'(tx_if.Tx_Busy_o), 32'd0);
        chk("rst done", 32'(tx_if.Frame_Done_o), 32'd0);
        chk("rst temt", 32'(tx_if.Tx_Shift_Empty_o), 32'd1);

        queue_frame(7'h03, 8'hA5);
        repeat (3) @(negedge clk);
        chk("rst temt2", 32'(tx_if.Tx_Shift_Empty_o), 32'd0);
        chk("rst nopop", 32'(tx_if.Tx_FIFO_Pop_o), 32'd0);
        rst = 1'b0;
        check_frame("8N1 A5", 1'b1);

        queue_frame(7'h1A, 8'h83);
        check_frame("7E1 83", 1'b1);
        queue_frame(7'h04, 8'h1F);
        check_frame("5N15", 1'b1);
        queue_frame(7'h07, 8'h1F);
        check_frame("8N2", 1'b1);
        queue_frame(7'h3B, 8'hFF);
        check_frame("stk1", 1'b1);
        queue_frame(7'h2B, 8'hFF);
        check_frame("stk0", 1'b1);
        queue_frame(7'h0B, 8'h01);
        check_frame("8O1", 1'b1);

        tick_div = 3;
        queue_frame(7'h03, 8'h5C);
        check_frame("div3", 1'b1);
        tick_div = 1;
        repeat (4) @(negedge clk);

        pc0 = pop_cnt;
        queue_frame(7'h03, 8'h11);
        queue_frame(7'h03, 8'h22);
        queue_frame(7'h03, 8'h33);
        check_frame("b2b0", 1'b0);
        check_frame("b2b1", 1'b0);
        check_frame("b2b2", 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b pops", pop_cnt - pc0, 3);

        tx_if.LCR_i = 7'h03;
        fifo_q.push_back(8'h00);
        wait_pop("rmid", got);
        repeat (40) @(negedge clk);
        chk("rmid sout0", 32'(tx_if.SOUT_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid sout", 32'(tx_if.SOUT_o), 32'd1);
        chk("rmid busy", 32'(tx_if.Tx_Busy_o), 32'd0);
        chk("rmid pop", 32'(tx_if.Tx_FIFO_Pop_o), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rmid idle", 32'(tx_if.Tx_Busy_o), 32'd0);
        chk("rmid temt", 32'(tx_if.Tx_Shift_Empty_o), 32'd1);

        fifo_q.push_back(8'hFF);
        wait_pop("brk", got);
        k = 0;
        repeat (40) begin @(negedge clk); k++; end
        chk("brk pre", 32'(tx_if.SOUT_o), 32'd1);
        tx_if.LCR_i = 7'h43;
        @(negedge clk); k++;
        chk("brk on", 32'(tx_if.SOUT_o), 32'd0);
        repeat (20) begin @(negedge clk); k++; end
        chk("brk hold", 32'(tx_if.SOUT_o), 32'd0);
        chk("brk busy", 32'(tx_if.Tx_Busy_o), 32'd1);
        tx_if.LCR_i = 7'h03;
        repeat (8) begin @(negedge clk); k++; end
        chk("brk off", 32'(tx_if.SOUT_o), 32'd1);
        done = 1'b0;
        while (!done && k < 1000) begin
            @(negedge clk); k++;
            if (tx_if.Frame_Done_o === 1'b1) done = 1'b1;
        end
        chk("brk done", 32'(done), 32'd1);
        chk("brk clk", k, 160);

        repeat (4) @(negedge clk);
        chk("underflow", underflow, 0);
        chk("pop gap", 32'(min_gap >= 2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
